// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and default widths.
// The PC block uses the same width constants.
package instr_fetch_unit_pkg;

   localparam int unsigned ADDR_W_DEF  = 16;
   localparam int unsigned INSTR_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, PC control,
// registered instruction/PC handoff to the decoder.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               fetch_en,
   input  logic [ADDR_W-1:0]  pc_cur,
   output logic               pc_enable,
   output logic               pc_load,
   output logic [ADDR_W-1:0]  pc_in,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc
);

   ifu_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  opc_q, opc_d;

   logic redir;
   logic req_fire;

   // Gate with reset_n so every output is quiet while in reset.
   assign redir = reset_n & redirect_valid;

   assign imem_req_valid = reset_n
                         & (state_q == ST_REQ)
                         & fetch_en
                         & ~redirect_valid;
   assign imem_addr = reset_n ? pc_cur : '0;
   assign req_fire  = imem_req_valid & imem_req_ready;

   assign pc_enable = redir | req_fire;
   assign pc_load   = redir;
   assign pc_in     = redir ? redirect_pc : '0;

   assign out_valid = reset_n
                    & (state_q == ST_HOLD)
                    & ~redirect_valid;
   assign out_instr = instr_q;
   assign out_pc    = opc_q;

   always_comb begin
      state_d  = state_q;
      req_pc_d = req_pc_q;
      instr_d  = instr_q;
      opc_d    = opc_q;
      unique case (state_q)
         ST_REQ: begin
            if (req_fire) begin
               state_d  = ST_WAIT;
               req_pc_d = pc_cur;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               state_d = imem_rsp_valid ? ST_REQ
                                        : ST_DRAIN;
            end else if (imem_rsp_valid) begin
               state_d = ST_HOLD;
               instr_d = imem_rsp_data;
               opc_d   = req_pc_q;
            end
         end
         // Stale data is dropped whether or not a redirect hits too.
         ST_DRAIN: begin
            if (imem_rsp_valid) state_d = ST_REQ;
         end
         ST_HOLD: begin
            if (redirect_valid || (out_valid && out_ready))
               state_d = ST_REQ;
         end
         default: state_d = ST_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_REQ;
         req_pc_q <= '0;
         instr_q  <= '0;
         opc_q    <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
         instr_q  <= instr_d;
         opc_q    <= opc_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC and memory models plus
// a scoreboard of expected fetches checked at each handshake.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic [15:0] pc_cur = 16'h0;
   logic        pc_enable, pc_load;
   logic [15:0] pc_in;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [15:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [15:0] imem_rsp_data = 16'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_instr, out_pc;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0;

   int checks = 0;
   int errors = 0;
   int dlv_cnt = 0;
   int pcen_cnt = 0;
   int mem_lat = 1;

   logic [15:0] sb[$];
   logic        s_acc = 1'b0, s_pcen = 1'b0, s_pcld = 1'b0;
   logic [15:0] s_addr = 16'h0, s_pcin = 16'h0;
   logic [15:0] pend = 16'h0;
   int          cnt = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .fetch_en       (fetch_en),
      .pc_cur         (pc_cur),
      .pc_enable      (pc_enable),
      .pc_load        (pc_load),
      .pc_in          (pc_in),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // PC register and memory, updated just after each rising edge
   always @(posedge clk) begin
      #1;
      if (!reset_n) begin
         pc_cur = 16'h0;
         cnt = 0;
         imem_rsp_valid = 1'b0;
         imem_rsp_data = 16'h0;
      end else begin
         if (s_pcen) pc_cur = s_pcld ? s_pcin : pc_cur + 16'd1;
         imem_rsp_valid = 1'b0;
         if (s_acc) begin
            pend = s_addr;
            cnt = mem_lat;
         end
         if (cnt != 0) begin
            if (cnt == 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data = pend ^ 16'hA5A5;
            end
            cnt = cnt - 1;
         end
      end
   end

   task automatic monitor();
      logic [15:0] e;
      forever begin
         @(negedge clk);
         s_acc  = reset_n & imem_req_valid & imem_req_ready;
         s_addr = imem_addr;
         s_pcen = reset_n & pc_enable;
         s_pcld = pc_load;
         s_pcin = pc_in;
         if (!reset_n) begin
            sb.delete();
         end else begin
            checks++;
            if (pc_load !== redirect_valid) begin
               errors++;
               $display("FAIL pc_load got %b exp %b",
                        pc_load, redirect_valid);
            end
            checks++;
            if (pc_enable !== (redirect_valid |
                (imem_req_valid & imem_req_ready))) begin
               errors++;
               $display("FAIL pc_enable got %b redir %b req %b rdy %b",
                        pc_enable, redirect_valid,
                        imem_req_valid, imem_req_ready);
            end
            if (imem_req_valid) begin
               checks++;
               if (imem_addr !== pc_cur) begin
                  errors++;
                  $display("FAIL imem_addr got %h exp %h",
                           imem_addr, pc_cur);
               end
            end
            if (pc_enable) pcen_cnt++;
            if (out_valid && out_ready) begin
               dlv_cnt++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected got pc %h exp none",
                           out_pc);
               end else begin
                  e = sb.pop_front();
                  if (out_pc !== e ||
                      out_instr !== (e ^ 16'hA5A5)) begin
                     errors++;
                     $display("FAIL sb_out got %h/%h exp %h/%h",
                              out_pc, out_instr, e, e ^ 16'hA5A5);
                  end
               end
            end
            if (redirect_valid) sb.delete();
            if (s_acc) sb.push_back(pc_cur);
         end
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) next();
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         next();
         #1;
         if (out_valid) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit ok;
      int d0, p0;
      reset_n = 1'b0;
      fetch_en = 1'b1;
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      mem_lat = 1;
      redirect_valid = 1'b1;
      redirect_pc = 16'h1234;
      idle(2);
      #1;
      checks++;
      if ({pc_enable, pc_load, pc_in, imem_req_valid, imem_addr,
           out_valid, out_instr, out_pc} !== 68'h0) begin
         errors++;
         $display("FAIL reset_outputs got %b%b %h %b %h %b %h %h exp 0",
                  pc_enable, pc_load, pc_in, imem_req_valid,
                  imem_addr, out_valid, out_instr, out_pc);
      end
      redirect_valid = 1'b0;
      d0 = dlv_cnt;
      p0 = pcen_cnt;
      next();
      reset_n = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0 ||
          pc_enable !== 1'b1) begin
         errors++;
         $display("FAIL first_req got v%b a%h en%b exp v1 a0000 en1",
                  imem_req_valid, imem_addr, pc_enable);
      end
      wait_valid(10, ok);
      checks++;
      if (!ok || out_instr !== 16'hA5A5 || out_pc !== 16'h0) begin
         errors++;
         $display("FAIL first_out got ok%b %h/%h exp 1 a5a5/0000",
                  ok, out_instr, out_pc);
      end
      idle(20);
      fetch_en = 1'b0;
      idle(8);
      checks++;
      if ((dlv_cnt - d0) !== (pcen_cnt - p0) ||
          (dlv_cnt - d0) < 5) begin
         errors++;
         $display("FAIL pcen_per_fetch got %0d pulses exp %0d (>=5)",
                  pcen_cnt - p0, dlv_cnt - d0);
      end
      checks++;
      if (pc_cur !== 16'(dlv_cnt - d0) || sb.size() != 0) begin
         errors++;
         $display("FAIL pc_after_run got %h sb %0d exp %h sb 0",
                  pc_cur, sb.size(), 16'(dlv_cnt - d0));
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [15:0] a0;
      a0 = pc_cur;
      imem_req_ready = 1'b0;
      fetch_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) next();
         #1;
         checks++;
         if (imem_req_valid !== 1'b1 || imem_addr !== a0 ||
             pc_enable !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got v%b a%h en%b exp v1 a%h en0",
                     i, imem_req_valid, imem_addr, pc_enable, a0);
         end
      end
      next();
      imem_req_ready = 1'b1;
      #1;
      checks++;
      if (pc_enable !== 1'b1 || imem_addr !== a0) begin
         errors++;
         $display("FAIL bp_accept got en%b a%h exp en1 a%h",
                  pc_enable, imem_addr, a0);
      end
      wait_valid(10, ok);
      fetch_en = 1'b0;
      checks++;
      if (!ok || out_pc !== a0) begin
         errors++;
         $display("FAIL bp_out got ok%b pc %h exp 1 %h", ok, out_pc, a0);
      end
      idle(6);
   endtask

   task automatic test_stall();
      bit ok;
      logic [15:0] a0;
      a0 = pc_cur;
      out_ready = 1'b0;
      fetch_en = 1'b1;
      wait_valid(10, ok);
      for (int i = 0; i < 4; i++) begin
         if (i != 0) begin
            next();
            #1;
         end
         checks++;
         if (!ok || out_valid !== 1'b1 || out_pc !== a0 ||
             out_instr !== (a0 ^ 16'hA5A5) ||
             imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall%0d got v%b %h/%h req%b exp v1 %h/%h req0",
                     i, out_valid, out_pc, out_instr, imem_req_valid,
                     a0, a0 ^ 16'hA5A5);
         end
      end
      out_ready = 1'b1;
      next();
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== a0 + 16'd1) begin
         errors++;
         $display("FAIL stall_next_req got v%b a%h exp v1 a%h",
                  imem_req_valid, imem_addr, a0 + 16'd1);
      end
      fetch_en = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL fetch_en_gate got %b exp 0", imem_req_valid);
      end
      idle(4);
   endtask

   task automatic test_redirect_wait();
      bit ok;
      bit seen;
      mem_lat = 3;
      fetch_en = 1'b1;
      next();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0100;
      #1;
      checks++;
      if (pc_enable !== 1'b1 || pc_load !== 1'b1 ||
          pc_in !== 16'h0100 || imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rw_redir got en%b ld%b in%h req%b exp 1 1 0100 0",
                  pc_enable, pc_load, pc_in, imem_req_valid);
      end
      next();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rw_drain got req%b v%b exp 0 0",
                  imem_req_valid, out_valid);
      end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         next();
         #1;
         if (out_valid) begin
            errors++;
            $display("FAIL rw_stale got out_valid 1 pc %h exp 0", out_pc);
         end
         if (imem_req_valid) seen = 1'b1;
      end
      checks++;
      if (!seen || imem_addr !== 16'h0100) begin
         errors++;
         $display("FAIL rw_next_addr got seen%b a%h exp 1 0100",
                  seen, imem_addr);
      end
      wait_valid(20, ok);
      fetch_en = 1'b0;
      checks++;
      if (!ok || out_pc !== 16'h0100 || out_instr !== 16'hA4A5) begin
         errors++;
         $display("FAIL rw_out got ok%b %h/%h exp 1 0100/a4a5",
                  ok, out_pc, out_instr);
      end
      idle(8);
      mem_lat = 1;
   endtask

   task automatic test_redirect_hold();
      bit ok;
      int d0;
      out_ready = 1'b0;
      fetch_en = 1'b1;
      wait_valid(10, ok);
      d0 = dlv_cnt;
      redirect_valid = 1'b1;
      redirect_pc = 16'h0200;
      out_ready = 1'b1;
      #1;
      checks++;
      if (!ok || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rh_valid got ok%b v%b exp 1 0", ok, out_valid);
      end
      next();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0200 ||
          dlv_cnt != d0) begin
         errors++;
         $display("FAIL rh_next got v%b a%h dlv+%0d exp 1 0200 +0",
                  imem_req_valid, imem_addr, dlv_cnt - d0);
      end
      wait_valid(10, ok);
      fetch_en = 1'b0;
      checks++;
      if (!ok || out_pc !== 16'h0200) begin
         errors++;
         $display("FAIL rh_out got ok%b pc %h exp 1 0200", ok, out_pc);
      end
      idle(6);
   endtask

   task automatic test_wrap();
      bit ok;
      redirect_valid = 1'b1;
      redirect_pc = 16'hFFFF;
      next();
      redirect_valid = 1'b0;
      fetch_en = 1'b1;
      out_ready = 1'b1;
      wait_valid(10, ok);
      checks++;
      if (!ok || out_pc !== 16'hFFFF || out_instr !== 16'h5A5A) begin
         errors++;
         $display("FAIL wrap_ffff got ok%b %h/%h exp 1 ffff/5a5a",
                  ok, out_pc, out_instr);
      end
      wait_valid(10, ok);
      fetch_en = 1'b0;
      checks++;
      if (!ok || out_pc !== 16'h0000 || out_instr !== 16'hA5A5) begin
         errors++;
         $display("FAIL wrap_0000 got ok%b %h/%h exp 1 0000/a5a5",
                  ok, out_pc, out_instr);
      end
      idle(6);
   endtask

   task automatic test_async_reset();
      bit ok;
      mem_lat = 3;
      fetch_en = 1'b1;
      next();
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({pc_enable, pc_load, pc_in, imem_req_valid, imem_addr,
           out_valid, out_instr, out_pc} !== 68'h0) begin
         errors++;
         $display("FAIL async_rst got %b%b %h %b %h %b %h %h exp 0",
                  pc_enable, pc_load, pc_in, imem_req_valid,
                  imem_addr, out_valid, out_instr, out_pc);
      end
      next();
      reset_n = 1'b1;
      mem_lat = 1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0) begin
         errors++;
         $display("FAIL rst_restart got v%b a%h exp 1 0000",
                  imem_req_valid, imem_addr);
      end
      wait_valid(10, ok);
      fetch_en = 1'b0;
      checks++;
      if (!ok || out_pc !== 16'h0 || out_instr !== 16'hA5A5) begin
         errors++;
         $display("FAIL rst_out got ok%b %h/%h exp 1 0000/a5a5",
                  ok, out_pc, out_instr);
      end
      idle(6);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d exp 0", sb.size());
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_backpressure();
      test_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
